// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multi-cycle execute stage.
//   Forwarding muxes pick op1/op2. The ALU runs single-cycle ops.
//   An iterative engine runs unsigned MUL/DIVU/REMU over WIDTH cycles.
//   The CCR {V,C,N,Z} is registered inside this block.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   in_valid/in_ready  operation handshake; flush aborts in-flight work
//   imm_or_reg, select_src, select_dst  operand source selection
//   alu_control, flag_we  opcode and CCR write enable
//   reg_src, reg_dst, immediate, *_from_ex, *_from_mem  operand values
//   out_valid          one-cycle pulse qualifying result/result_hi/ccr
//   result, result_hi  result (MUL: low/high halves)
//   first_operand      op1 captured at accept
//   ccr                {V,C,N,Z}
//   busy               multi-cycle op iterating (stall)
module execute_unit_mc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             imm_or_reg,
    input  logic [1:0]       select_src,
    input  logic [1:0]       select_dst,
    input  logic [3:0]       alu_control,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] reg_src,
    input  logic [WIDTH-1:0] reg_dst,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] src_from_ex,
    input  logic [WIDTH-1:0] dst_from_ex,
    input  logic [WIDTH-1:0] src_from_mem,
    input  logic [WIDTH-1:0] dst_from_mem,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] first_operand,
    output logic [3:0]       ccr,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT, OP_PASSB,
        OP_INC, OP_DEC, OP_PASSA, OP_MUL, OP_DIVU, OP_REMU, OP_NOP0, OP_NOP1
    } aluOp_t;

    state_t state, stateNext;
    aluOp_t opIn, opR;

    logic [WIDTH-1:0] op1, op2;
    logic             accept, isMulti, isNop, divZero;
    logic             flagWeR, divZeroR;
    logic [CNT_W-1:0] counter;

    // Iteration registers: MUL keeps {partial product, multiplier};
    // DIVU/REMU keep {remainder, dividend/quotient}.
    logic [WIDTH-1:0] accHi, accLo, opB;
    logic [WIDTH:0]   mulSum, divTrial;

    logic [WIDTH-1:0] aluRes, finRes, finHi;
    logic             aluC, aluV, finV, finZ;
    logic [WIDTH:0]   addSum, subDiff, shlWide, shrWide, incWide, decWide;

    assign opIn = aluOp_t'(alu_control);

    always_comb begin
        case (select_src)
            2'b01:   op1 = src_from_ex;
            2'b10:   op1 = src_from_mem;
            default: op1 = reg_src;
        endcase
        case (select_dst)
            2'b01:   op2 = dst_from_ex;
            2'b10:   op2 = dst_from_mem;
            default: op2 = imm_or_reg ? reg_dst : immediate;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == BUSY);
    assign accept   = in_valid & in_ready & ~flush;
    assign isMulti  = (opIn == OP_MUL) || (opIn == OP_DIVU) || (opIn == OP_REMU);
    assign isNop    = (opIn == OP_NOP0) || (opIn == OP_NOP1);
    assign divZero  = ((opIn == OP_DIVU) || (opIn == OP_REMU)) && (op2 == '0);

    // Single-cycle ALU. Shifts run in a WIDTH+1 window so the extra bit is the
    // last bit shifted out; oversize amounts naturally give result 0, C 0.
    assign addSum  = {1'b0, op1} + {1'b0, op2};
    assign subDiff = {1'b0, op2} - {1'b0, op1};
    assign shlWide = {1'b0, op1} << op2;
    assign shrWide = {op1, 1'b0} >> op2;
    assign incWide = {1'b0, op1} + (WIDTH + 1)'(1);
    assign decWide = {1'b0, op1} - (WIDTH + 1)'(1);

    always_comb begin
        aluRes = '0;
        aluC   = ccr[2];
        aluV   = ccr[3];
        case (opIn)
            OP_ADD: begin
                aluRes = addSum[WIDTH-1:0];
                aluC   = addSum[WIDTH];
                aluV   = (op1[WIDTH-1] == op2[WIDTH-1]) && (addSum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes = subDiff[WIDTH-1:0];
                aluC   = subDiff[WIDTH];
                aluV   = (op1[WIDTH-1] != op2[WIDTH-1]) && (subDiff[WIDTH-1] != op2[WIDTH-1]);
            end
            OP_AND:   aluRes = op1 & op2;
            OP_OR:    aluRes = op1 | op2;
            OP_NOT:   aluRes = ~op1;
            OP_PASSB: aluRes = op2;
            OP_PASSA: aluRes = op1;
            OP_SHL: begin
                aluRes = shlWide[WIDTH-1:0];
                aluC   = shlWide[WIDTH];
            end
            OP_SHR: begin
                aluRes = shrWide[WIDTH:1];
                aluC   = shrWide[0];
            end
            OP_INC: begin
                aluRes = incWide[WIDTH-1:0];
                aluC   = incWide[WIDTH];
                aluV   = (op1 == {1'b0, {(WIDTH - 1){1'b1}}});
            end
            OP_DEC: begin
                aluRes = decWide[WIDTH-1:0];
                aluC   = decWide[WIDTH];
                aluV   = (op1 == {1'b1, {(WIDTH - 1){1'b0}}});
            end
            default: ;
        endcase
    end

    // One shift-add step and one restoring-divide step per BUSY cycle.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    assign divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opB};

    // Divide-by-zero preloads accLo='1 and accHi=op1, so the same selection
    // yields the required DIVU/REMU results without iterating.
    always_comb begin
        finRes = accLo;
        finHi  = '0;
        finV   = divZeroR;
        case (opR)
            OP_MUL: begin
                finHi = accHi;
                finV  = |accHi;
            end
            OP_REMU: finRes = accHi;
            default: ;
        endcase
        finZ = (opR == OP_MUL) ? ~|{accHi, accLo} : ~|finRes;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept && isMulti) stateNext = divZero ? DONE : BUSY;
            BUSY: begin
                if (flush)                       stateNext = IDLE;
                else if (counter == CNT_W'(1))   stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            result_hi     <= '0;
            first_operand <= '0;
            ccr           <= 4'b0000;
            counter       <= '0;
            opR           <= OP_ADD;
            flagWeR       <= 1'b0;
            divZeroR      <= 1'b0;
            accHi         <= '0;
            accLo         <= '0;
            opB           <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    first_operand <= op1;
                    if (isMulti) begin
                        opR      <= opIn;
                        flagWeR  <= flag_we;
                        divZeroR <= divZero;
                        if (divZero) begin
                            accHi   <= op1;
                            accLo   <= '1;
                            opB     <= op2;
                            counter <= '0;
                        end else if (opIn == OP_MUL) begin
                            accHi   <= '0;
                            accLo   <= op2;
                            opB     <= op1;
                            counter <= CNT_W'(WIDTH);
                        end else begin
                            accHi   <= '0;
                            accLo   <= op1;
                            opB     <= op2;
                            counter <= CNT_W'(WIDTH);
                        end
                    end else if (!isNop) begin
                        out_valid <= 1'b1;
                        result    <= aluRes;
                        result_hi <= '0;
                        if (flag_we) ccr <= {aluV, aluC, aluRes[WIDTH-1], ~|aluRes};
                    end
                end
                BUSY: begin
                    if (flush) begin
                        counter <= '0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                        if (opR == OP_MUL) begin
                            {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
                        end else if (!divTrial[WIDTH]) begin
                            accHi <= divTrial[WIDTH-1:0];
                            accLo <= {accLo[WIDTH-2:0], 1'b1};
                        end else begin
                            accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
                            accLo <= {accLo[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DONE: if (!flush) begin
                    out_valid <= 1'b1;
                    result    <= finRes;
                    result_hi <= finHi;
                    if (flagWeR) ccr <= {finV, ccr[2], finRes[WIDTH-1], finZ};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/execute_unit_mc.md
Name: execute_unit_mc

Overview:
- Parametrised, multi-cycle successor of the single-cycle execute stage. It sits between decode/register-read and the memory stage.
- Operand forwarding muxes, ALU and condition-code register (CCR) live in one block. The CCR is now registered inside the block rather than produced combinationally.
- Adds unsigned multiply, divide and remainder, computed iteratively over WIDTH cycles.
- Uses a valid/ready handshake, a busy/stall output and a flush input.

Parameters:
- WIDTH, 16, datapath width in bits; ≥4.
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block can accept an operation.
- flush  in  1  abort any in-flight op; drop the accepting op.
- imm_or_reg  in  1  1: second operand = reg_dst; 0: immediate.
- select_src  in  2  00 reg_src, 01 src_from_ex, 10 src_from_mem, 11 reg_src.
- select_dst  in  2  00 reg/imm, 01 dst_from_ex, 10 dst_from_mem, 11 reg/imm.
- alu_control  in  4  opcode (see Behaviour).
- flag_we  in  1  op updates CCR on completion.
- reg_src, reg_dst, immediate  in  WIDTH each  operands.
- src_from_ex, dst_from_ex, src_from_mem, dst_from_mem  in  WIDTH each  forwarded values.
- out_valid  out  1  one-cycle pulse; result fields valid.
- result  out  WIDTH  result; low half for MUL.
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- first_operand  out  WIDTH  registered forwarded op1, captured at accept.
- ccr  out  4  {V, C, N, Z}: bit3 V, bit2 C, bit1 N, bit0 Z.
- busy  out  1  multi-cycle op in flight (pipeline stall).

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; busy=0; result=0; result_hi=0; first_operand=0; ccr=4'b0000; counter=0.
- Operand selection: op1/op2 via select_src/select_dst. The 11 code behaves as 00. Sampled only at accept; internal registers hold them afterwards.
- Accept: in_valid & in_ready & ~flush.
- Opcodes:
  - 0000 ADD op1+op2, C=carry.
  - 0001 SUB op2−op1, C=borrow.
  - 0010 AND; 0011 OR; 0110 NOT op1; 0111 pass op2; 1010 pass op1. These ops leave C and V unchanged.
  - 0100 SHL op1<<op2: amount 0 → C=0; amount 1..WIDTH → C=last bit shifted out; amount >WIDTH → result 0, C=0.
  - 0101 SHR op1>>op2: same shift-amount rules.
  - 1000 INC op1+1; 1001 DEC op1−1; C=carry/borrow.
  - 1011 MUL unsigned op1*op2, 2·WIDTH product.
  - 1100 DIVU op1/op2; 1101 REMU op1%op2.
  - 1110, 1111 NOP: accepted, no out_valid, no CCR change.
- V flag:
  - ADD/SUB/INC/DEC: signed overflow.
  - MUL: 1 iff result_hi≠0.
  - DIVU/REMU: 1 iff divide-by-zero.
  - Logic/shift/pass: V unchanged.
- N = result[WIDTH-1]; Z = (result==0). For MUL, Z covers the full 2·WIDTH product.
- FSM:
  - IDLE: on accept of a single-cycle op, register results and pulse out_valid the next cycle; stay IDLE. Latency is 1 and throughput is 1 per cycle.
  - IDLE→BUSY: on accept of MUL/DIVU/REMU. in_ready=0, busy=1, counter=WIDTH.
  - BUSY: one shift-add or restoring-divide step per cycle; counter decrements.
  - BUSY→DONE: when the counter reaches 0.
  - DONE: out_valid=1 for one cycle, result fields updated; next state IDLE, in_ready=1.
  - Multi-cycle latency from the accept edge to out_valid is WIDTH+1 clocks.
- Divide-by-zero is detected at accept and skips iteration: DONE follows one cycle later. DIVU result = all ones; REMU result = op1; V=1.
- CCR is written in the same cycle out_valid rises, and only if flag_we was 1 at accept. Otherwise ccr holds. result holds between out_valid pulses.
- flush:
  - In IDLE: blocks the accept.
  - In BUSY or DONE: return to IDLE next cycle; no out_valid; ccr and result unchanged.
  - flush has priority over in_valid.
- rst_n asserted mid-operation: immediate return to reset values; the in-flight op is lost.
- in_valid while busy: ignored (in_ready=0). Upstream must hold the op.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001, flag_we=1 → next cycle out_valid=1, result=0x8000, ccr=V1 C0 N1 Z0.
- SUB with reg_src=5, select_dst=01, dst_from_ex=3 → result=0xFFFE, C=1 (borrow), N=1. first_operand=5.
- MUL 0x1234*0x0100 → busy=1 and in_ready=0 for 16 cycles; out_valid 17 clocks after accept; result=0x3400, result_hi=0x0012, V=1.
- DIVU 100/7 → result=14. REMU 100/7 → result=2. DIVU 5/0 → out_valid one cycle after DONE entry, result=0xFFFF, V=1.
- Start MUL, assert flush at iteration 5 → no out_valid, ccr unchanged, in_ready=1 the next cycle. Repeat with rst_n pulsed low mid-MUL → all outputs return to reset values asynchronously.
- SHR 0x8001 by 1 → result=0x4000, C=1. SHL 0x0001 by 20 → result=0, C=0, Z=1. AND with flag_we=0 → ccr unchanged.
